bcd_down_timer: RTL and testbench

- Multi-digit BCD countdown timer. It is the down-counting counterpart of the team's BCD up-counter.
- Loads a BCD preset and decrements it once per prescaled tick, with borrow ripple across digits.
- Flags terminal count with a one-cycle done pulse.
- Sits between control logic (load/start/pause) and display/decoder logic that consumes the packed BCD digits.

---
 rtl/bcd_timer_pkg.sv | 19 +
 rtl/bcd_down_timer_if.sv | 23 ++
 rtl/bcd_digit_dn.sv | 25 ++
 rtl/bcd_down_timer.sv | 127 ++++++++++++
 tb/tb_bcd_down_timer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  // Any non-decimal nibble saturates to 9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// Control/display bundle of the BCD countdown timer.
interface bcd_down_timer_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   bcd;
  logic                  running;
  logic                  zero;
  logic                  done;

  modport master (
    output load, load_val, start, pause,
    input  bcd, running, zero, done
  );

  modport slave (
    input  load, load_val, start, pause,
    output bcd, running, zero, done
  );
endinterface

// File: rtl/bcd_digit_dn.sv
// One combinational BCD digit decrement stage with borrow in/out.
module bcd_digit_dn
  import bcd_timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               borrow_out
);

  // 0 with a borrow wraps to 9 and passes the borrow upward.
  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == '0) begin
        digit_out  = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with prescaled decrement and done pulse.
// Optional macro BCD_DOWN_RELOAD_EN: reload the preset after terminal count
// and keep running (free-running divide-by-(N+1)).
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  bcd_down_timer_if.slave   bus
);

  localparam int W  = DIGIT_W * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t          state_q, state_d;
  logic [W-1:0]    bcd_q, bcd_d;
  logic [W-1:0]    dec_val;
  logic [W-1:0]    load_clamped;
  logic [PW-1:0]   presc_q, presc_d;
  logic            done_q, done_d;
  logic [DIGITS:0] borrow;
  logic            tick;
  logic            is_zero;
`ifdef BCD_DOWN_RELOAD_EN
  logic [W-1:0]    reload_q, reload_d;
`endif

  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign load_clamped[g*DIGIT_W +: DIGIT_W] =
      clamp_digit(bus.load_val[g*DIGIT_W +: DIGIT_W]);

    bcd_digit_dn u_dig (
      .digit_in  (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .borrow_in (borrow[g]),
      .digit_out (dec_val[g*DIGIT_W +: DIGIT_W]),
      .borrow_out(borrow[g+1])
    );
  end

  // The borrow ripples out of the top digit only when every digit is 0.
  assign is_zero = borrow[DIGITS];
  assign tick    = (presc_q == PW'(TICK_DIV - 1));

  // Next-state, count and prescaler; load beats start beats pause.
  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
`ifdef BCD_DOWN_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      bcd_d    = load_clamped;
      presc_d  = '0;
      state_d  = IDLE;
`ifdef BCD_DOWN_RELOAD_EN
      reload_d = load_clamped;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (bus.start && !is_zero) state_d = RUN;
        RUN: begin
          if (bus.pause && !bus.start) begin
            state_d = PAUSED;
          end else if (tick) begin
            presc_d = '0;
`ifdef BCD_DOWN_RELOAD_EN
            if (is_zero) begin
              bcd_d = reload_q;
            end else begin
              bcd_d = dec_val;
              if (dec_val == '0) begin
                done_d = 1'b1;
                if (reload_q == '0) state_d = DONE;
              end
            end
`else
            bcd_d = dec_val;
            if (dec_val == '0) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
`endif
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSED: if (bus.start) state_d = RUN;
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, count, prescaler and done registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
`ifdef BCD_DOWN_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
`ifdef BCD_DOWN_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.bcd     = bcd_q;
  assign bus.running = (state_q == RUN);
  assign bus.zero    = is_zero;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: two instances (TICK_DIV 1 and 4) share stimulus
// and are checked every cycle against an integer-valued behavioural model.
module tb_bcd_down_timer;

  localparam int DG  = 2;
  localparam int TD0 = 1;
  localparam int TD1 = 4;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       load  = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] load_val = '0;

  bcd_down_timer_if #(.DIGITS(DG)) bus0 ();
  bcd_down_timer_if #(.DIGITS(DG)) bus1 ();

  assign bus0.load = load;  assign bus0.load_val = load_val;
  assign bus0.start = start; assign bus0.pause = pause;
  assign bus1.load = load;  assign bus1.load_val = load_val;
  assign bus1.start = start; assign bus1.pause = pause;

  bcd_down_timer #(.DIGITS(DG), .TICK_DIV(TD0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bcd_down_timer #(.DIGITS(DG), .TICK_DIV(TD1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [7:0] o_bcd  [2];
  logic       o_run  [2];
  logic       o_zero [2];
  logic       o_done [2];
  assign o_bcd[0] = bus0.bcd;  assign o_run[0] = bus0.running;
  assign o_zero[0] = bus0.zero; assign o_done[0] = bus0.done;
  assign o_bcd[1] = bus1.bcd;  assign o_run[1] = bus1.running;
  assign o_zero[1] = bus1.zero; assign o_done[1] = bus1.done;

  // ---------------- behavioural model (count held as a plain integer)
  typedef struct packed {
    int   val;
    int   rel;
    int   mode;
    int   ph;
    logic done;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t mreset();
    mdl_t r;
    r.val = 0; r.rel = 0; r.mode = M_IDLE; r.ph = 0; r.done = 1'b0;
    return r;
  endfunction

  function automatic int clamp_val(logic [7:0] v);
    int r = 0;
    int d;
    for (int k = DG - 1; k >= 0; k--) begin
      d = int'(v[k*4 +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    logic [7:0] r;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'((v / 10) % 10);
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t s, int td, logic ld, logic [7:0] lv,
                                 logic st, logic pa);
    mdl_t n = s;
    n.done = 1'b0;
    if (ld) begin
      n.val = clamp_val(lv); n.rel = n.val; n.ph = 0; n.mode = M_IDLE;
      return n;
    end
    case (s.mode)
      M_IDLE: if (st && s.val != 0) n.mode = M_RUN;
      M_RUN: begin
        if (pa && !st) n.mode = M_PAUSED;
        else if (s.ph == td - 1) begin
          n.ph = 0;
          if (s.val == 0) n.val = s.rel;
          else begin
            n.val = s.val - 1;
            if (n.val == 0) begin
              n.done = 1'b1;
`ifdef BCD_DOWN_RELOAD_EN
              if (s.rel == 0) n.mode = M_DONE;
`else
              n.mode = M_DONE;
`endif
            end
          end
        end else n.ph = s.ph + 1;
      end
      M_PAUSED: if (st) n.mode = M_RUN;
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m[0] <= mreset();
      m[1] <= mreset();
    end else begin
      m[0] <= mstep(m[0], TD0, load, load_val, start, pause);
      m[1] <= mstep(m[1], TD1, load, load_val, start, pause);
    end
  end

  // ---------------- checking
  int passed = 0;
  int total  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_bcd%0d", i),  32'(o_bcd[i]),  32'(to_bcd(m[i].val)));
        chk($sformatf("model_run%0d", i),  32'(o_run[i]),  32'(m[i].mode == M_RUN));
        chk($sformatf("model_zero%0d", i), 32'(o_zero[i]), 32'(m[i].val == 0));
        chk($sformatf("model_done%0d", i), 32'(o_done[i]), 32'(m[i].done));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(int n);
    repeat (n) step();
  endtask

  task automatic chk_reset_state(string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_bcd"},  32'(o_bcd[i]),  32'h0);
      chk({tag, "_zero"}, 32'(o_zero[i]), 32'h1);
      chk({tag, "_run"},  32'(o_run[i]),  32'h0);
      chk({tag, "_done"}, 32'(o_done[i]), 32'h0);
    end
  endtask

  // ---------------- stimulus
  initial begin
    int n;
    #3;
    chk_reset_state("reset");
    steps(2);
    rst = 1'b1;
    step();

    // Countdown 21 -> 00 with TICK_DIV=1, including the 20->19 borrow.
    load = 1'b1; load_val = 8'h21; step(); load = 1'b0;
    chk("ld21", 32'(o_bcd[0]), 32'h21);
    chk("idle_run", 32'(o_run[0]), 32'h0);
    start = 1'b1; step(); start = 1'b0;
    chk("start_lat", 32'(o_run[0]), 32'h1);
    chk("start_bcd", 32'(o_bcd[0]), 32'h21);
    step(); chk("dec20", 32'(o_bcd[0]), 32'h20);
    step(); chk("borrow19", 32'(o_bcd[0]), 32'h19);
    chk("no_early_done", 32'(o_done[0]), 32'h0);
    steps(18);
    chk("at01", 32'(o_bcd[0]), 32'h01);
    chk("at01_done", 32'(o_done[0]), 32'h0);
    step();
    chk("at00", 32'(o_bcd[0]), 32'h00);
    chk("at00_done", 32'(o_done[0]), 32'h1);
    chk("at00_zero", 32'(o_zero[0]), 32'h1);
    step();
    chk("done_pulse", 32'(o_done[0]), 32'h0);
`ifdef BCD_DOWN_RELOAD_EN
    chk("reload_bcd", 32'(o_bcd[0]), 32'h21);
    chk("reload_run", 32'(o_run[0]), 32'h1);
`else
    chk("after_run", 32'(o_run[0]), 32'h0);
    chk("after_bcd", 32'(o_bcd[0]), 32'h00);
`endif

    // Load clamping.
    load = 1'b1; load_val = 8'h3F; step();
    chk("clamp3F", 32'(o_bcd[0]), 32'h39);
    load_val = 8'hA5; step();
    chk("clampA5", 32'(o_bcd[1]), 32'h95);
    load = 1'b0;

    // Pause/resume with TICK_DIV=4.
    load = 1'b1; load_val = 8'h10; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (o_bcd[1] != 8'h09 && n < 40) begin step(); n++; end
    chk("wait09", 32'(n < 40), 32'h1);
    steps(2);
    pause = 1'b1; steps(5); pause = 1'b0;
    chk("paused_bcd", 32'(o_bcd[1]), 32'h09);
    chk("paused_run", 32'(o_run[1]), 32'h0);
    start = 1'b1; step(); start = 1'b0;
    chk("resume_run", 32'(o_run[1]), 32'h1);
    chk("resume_bcd", 32'(o_bcd[1]), 32'h09);
    step(); chk("resume_p1", 32'(o_bcd[1]), 32'h09);
    step(); chk("resume_p2", 32'(o_bcd[1]), 32'h08);

    // Asynchronous reset mid-run.
    load = 1'b1; load_val = 8'h09; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (o_bcd[0] != 8'h07 && n < 20) begin step(); n++; end
    chk("wait07", 32'(n < 20), 32'h1);
    #2 rst = 1'b0;
    #1 chk_reset_state("midrst");
    steps(2);
    rst = 1'b1;
    steps(3);
    chk("norestart_run", 32'(o_run[0]), 32'h0);
    chk("norestart_bcd", 32'(o_bcd[0]), 32'h00);

    // Start ignored with count 0 in IDLE.
    start = 1'b1; step(); start = 1'b0;
    chk("idle0_run", 32'(o_run[0]), 32'h0);
    chk("idle0_done", 32'(o_done[0]), 32'h0);

    // Load 02, run to terminal, then poke start.
    load = 1'b1; load_val = 8'h02; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("l02_run", 32'(o_run[0]), 32'h1);
    step(); chk("l02_01", 32'(o_bcd[0]), 32'h01);
    step(); chk("l02_00", 32'(o_bcd[0]), 32'h00);
    chk("l02_done", 32'(o_done[0]), 32'h1);
`ifdef BCD_DOWN_RELOAD_EN
    step();
    chk("l02_reload", 32'(o_bcd[0]), 32'h02);
    chk("l02_run2", 32'(o_run[0]), 32'h1);
`else
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("done_start_bcd", 32'(o_bcd[0]), 32'h00);
    chk("done_start_run", 32'(o_run[0]), 32'h0);
    chk("done_start_done", 32'(o_done[0]), 32'h0);
`endif

    // Randomised traffic, checked by the per-cycle compare process.
    repeat (3000) begin
      load = ($urandom_range(0, 99) < 4);
      if (load) load_val = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                       : 8'($urandom_range(0, 6));
      start = ($urandom_range(0, 99) < 12);
      pause = ($urandom_range(0, 99) < 8);
      step();
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;
    steps(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
